// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch/data requester signals and memory-side handshake of mem_arbiter
interface mem_arbiter_if #(parameter int WIDTH = 32);
   logic             i_req;
   logic [WIDTH-1:0] i_addr;
   logic [WIDTH-1:0] o_i_rdata;
   logic             o_i_valid;
   logic             o_i_stall;
   logic             d_req;
   logic             d_we;
   logic [WIDTH-1:0] d_addr;
   logic [WIDTH-1:0] d_wdata;
   logic [WIDTH-1:0] o_d_rdata;
   logic             o_d_valid;
   logic             o_d_stall;
   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_ready;
   logic             mem_rvalid;
   logic [WIDTH-1:0] mem_rdata;
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rvalid, mem_rdata,
      output o_i_rdata, o_i_valid, o_i_stall, o_d_rdata, o_d_valid, o_d_stall,
      output mem_req, mem_we, mem_addr, mem_wdata
   );
   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_ready, mem_rvalid, mem_rdata,
      input  o_i_rdata, o_i_valid, o_i_stall, o_d_rdata, o_d_valid, o_d_stall,
      input  mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported memory between fetch and data, data first with a burst limit
module mem_arbiter #(
   parameter int WIDTH       = 32,
   parameter int MAX_D_BURST = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   localparam int BW = $clog2(MAX_D_BURST + 1);
   localparam logic [BW-1:0] BMAX = BW'(MAX_D_BURST);
   localparam logic [WIDTH-1:0] ZERO = '0;
   typedef enum logic [2:0] {IDLE, I_REQ, I_WAIT, D_REQ, D_WAIT} state_t;
   state_t state, state_n;
   logic [BW-1:0] burst_cnt;
   logic accept, grant_d, grant_i, i_done, d_load, d_store;
   assign accept = bus.mem_req & bus.mem_ready;
   assign bus.o_i_stall = bus.i_req & ~bus.o_i_valid;
   assign bus.o_d_stall = bus.d_req & ~bus.o_d_valid;
   always_comb begin
      state_n = state;
      grant_d = 1'b0;
      grant_i = 1'b0;
      i_done  = 1'b0;
      d_load  = 1'b0;
      d_store = 1'b0;
      case (state)
         IDLE: begin
            // a pending fetch only loses while the data burst is below its limit
            grant_d = bus.d_req & ((burst_cnt < BMAX) | ~bus.i_req);
            grant_i = ~grant_d & bus.i_req;
            state_n = grant_d ? D_REQ : grant_i ? I_REQ : IDLE;
         end
         I_REQ:  state_n = accept ? I_WAIT : I_REQ;
         I_WAIT: begin
            i_done  = bus.mem_rvalid;
            state_n = bus.mem_rvalid ? IDLE : I_WAIT;
         end
         D_REQ: begin
            d_store = accept & bus.mem_we;
            state_n = accept ? (bus.mem_we ? IDLE : D_WAIT) : D_REQ;
         end
         D_WAIT: begin
            d_load  = bus.mem_rvalid;
            state_n = bus.mem_rvalid ? IDLE : D_WAIT;
         end
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= IDLE;
         burst_cnt     <= '0;
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= ZERO;
         bus.mem_wdata <= ZERO;
         bus.o_i_valid <= 1'b0;
         bus.o_d_valid <= 1'b0;
         bus.o_i_rdata <= ZERO;
         bus.o_d_rdata <= ZERO;
      end else begin
         state         <= state_n;
         bus.o_i_valid <= i_done;
         bus.o_d_valid <= d_load | d_store;
         bus.mem_req   <= grant_d | grant_i | (bus.mem_req & ~bus.mem_ready);
         if (i_done) bus.o_i_rdata <= bus.mem_rdata;
         if (d_load) bus.o_d_rdata <= bus.mem_rdata;
         if (grant_d) begin
            bus.mem_we    <= bus.d_we;
            bus.mem_addr  <= bus.d_addr;
            bus.mem_wdata <= bus.d_wdata;
         end else if (grant_i) begin
            bus.mem_we   <= 1'b0;
            bus.mem_addr <= bus.i_addr;
         end
         burst_cnt <= grant_i ? '0 :
                      grant_d ? (bus.i_req ? (burst_cnt == BMAX ? burst_cnt : burst_cnt + 1'b1) : '0) :
                      burst_cnt;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter against a transaction-level model
module tb_mem_arbiter;
   localparam int W    = 32;
   localparam int MAXB = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int errs   = 0;
   bit force_low = 1'b0, rand_ready = 1'b0, spur_en = 1'b0, spur_now = 1'b0;
   int fixed_lat = 1;
   mem_arbiter_if #(.WIDTH(W)) bus();
   mem_arbiter #(.WIDTH(W), .MAX_D_BURST(MAXB)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   // model: one outstanding transaction record plus completion outputs
   bit         m_busy = 0, m_acc = 0, m_req = 0, m_kind_d = 0, m_we = 0;
   bit         m_ivalid = 0, m_dvalid = 0;
   logic [W-1:0] m_addr = '0, m_wdata = '0, m_irdata = '0, m_drdata = '0;
   int         m_burst = 0;

   function automatic logic [W-1:0] memf(input logic [W-1:0] a);
      return a == 32'h10 ? 32'h0051_0093 : {a[15:0], ~a[15:0]};
   endfunction

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_busy <= 0; m_acc <= 0; m_req <= 0; m_kind_d <= 0; m_we <= 0;
         m_ivalid <= 0; m_dvalid <= 0; m_addr <= '0; m_wdata <= '0;
         m_irdata <= '0; m_drdata <= '0; m_burst <= 0;
      end else begin
         m_ivalid <= 0;
         m_dvalid <= 0;
         if (!m_busy) begin
            if (bus.d_req && (m_burst < MAXB || !bus.i_req)) begin
               m_busy <= 1; m_acc <= 0; m_req <= 1; m_kind_d <= 1;
               m_we <= bus.d_we; m_addr <= bus.d_addr; m_wdata <= bus.d_wdata;
               m_burst <= bus.i_req ? (m_burst < MAXB ? m_burst + 1 : MAXB) : 0;
            end else if (bus.i_req) begin
               m_busy <= 1; m_acc <= 0; m_req <= 1; m_kind_d <= 0;
               m_we <= 0; m_addr <= bus.i_addr; m_burst <= 0;
            end
         end else if (!m_acc) begin
            if (bus.mem_ready) begin
               m_req <= 0;
               if (m_we) begin m_busy <= 0; m_dvalid <= 1; end
               else m_acc <= 1;
            end
         end else if (bus.mem_rvalid) begin
            m_busy <= 0;
            if (m_kind_d) begin m_dvalid <= 1; m_drdata <= bus.mem_rdata; end
            else begin m_ivalid <= 1; m_irdata <= bus.mem_rdata; end
         end
      end
   end

   task automatic compare();
      chk("mem_req", bus.mem_req, m_req);
      if (m_req) begin
         chk("mem_we", bus.mem_we, m_we);
         chk("mem_addr", bus.mem_addr, m_addr);
         if (m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      end
      chk("o_i_valid", bus.o_i_valid, m_ivalid);
      chk("o_d_valid", bus.o_d_valid, m_dvalid);
      chk("o_i_rdata", bus.o_i_rdata, m_irdata);
      chk("o_d_rdata", bus.o_d_rdata, m_drdata);
      chk("o_i_stall", bus.o_i_stall, bus.i_req & ~m_ivalid);
      chk("o_d_stall", bus.o_d_stall, bus.d_req & ~m_dvalid);
   endtask

   // memory: accepts reads, answers after a latency, optionally injects stray rvalid
   initial begin : responder
      bit acc, pend;
      int cnt;
      logic [W-1:0] aaddr, paddr;
      acc = 0; pend = 0; cnt = 0; aaddr = '0; paddr = '0;
      bus.mem_ready = 1'b1; bus.mem_rvalid = 1'b0; bus.mem_rdata = '0;
      forever begin
         @(negedge clk);
         acc   = rst && bus.mem_req && bus.mem_ready && !bus.mem_we;
         aaddr = bus.mem_addr;
         @(posedge clk);
         #1;
         bus.mem_rvalid = 1'b0;
         if (acc) begin
            pend = 1; paddr = aaddr;
            cnt = fixed_lat > 0 ? fixed_lat : int'($urandom_range(1, 3));
         end
         if (pend) begin
            if (cnt == 1) begin bus.mem_rvalid = 1'b1; bus.mem_rdata = memf(paddr); pend = 0; end
            else cnt--;
         end else if (spur_now || (spur_en && $urandom_range(0, 7) == 0)) begin
            bus.mem_rvalid = 1'b1; bus.mem_rdata = '1;
         end
         bus.mem_ready = force_low ? 1'b0 : rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_mem_req"}, bus.mem_req, 0);
      chk({tag, "_mem_we"}, bus.mem_we, 0);
      chk({tag, "_mem_addr"}, bus.mem_addr, 0);
      chk({tag, "_mem_wdata"}, bus.mem_wdata, 0);
      chk({tag, "_i_valid"}, bus.o_i_valid, 0);
      chk({tag, "_d_valid"}, bus.o_d_valid, 0);
      chk({tag, "_i_rdata"}, bus.o_i_rdata, 0);
      chk({tag, "_d_rdata"}, bus.o_d_rdata, 0);
   endtask

   task automatic wait_valid(input bit d, input string nm);
      int n = 0;
      while (!(d ? bus.o_d_valid : bus.o_i_valid) && n < 50) begin
         step();
         n++;
      end
      chk({nm, "_timeout"}, n < 50, 1);
   endtask

   initial begin
      logic [5:0] seq;
      int ng, nd;
      bit prev;
      bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0;
      #1 rst = 1'b0;
      fork
         forever begin @(negedge clk); compare(); end
      join_none
      step(); chk_zero("reset");
      step(); rst = 1'b1;
      // single fetch
      step(); bus.i_req = 1; bus.i_addr = 32'h10;
      #1 chk("t1_stall_c0", bus.o_i_stall, 1);
      step(); chk("t1_req_c1", bus.mem_req, 1); chk("t1_addr_c1", bus.mem_addr, 32'h10);
      chk("t1_stall_c1", bus.o_i_stall, 1);
      step(); chk("t1_stall_c2", bus.o_i_stall, 1); chk("t1_valid_c2", bus.o_i_valid, 0);
      step(); chk("t1_valid_c3", bus.o_i_valid, 1); chk("t1_rdata", bus.o_i_rdata, 32'h0051_0093);
      chk("t1_stall_c3", bus.o_i_stall, 0); bus.i_req = 0;
      // store beats simultaneous fetch
      step(); bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h100; bus.d_wdata = 32'hDEAD_BEEF;
      bus.i_req = 1; bus.i_addr = 32'h4;
      step(); chk("t2_req", bus.mem_req, 1); chk("t2_we", bus.mem_we, 1);
      chk("t2_addr", bus.mem_addr, 32'h100); chk("t2_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      step(); chk("t2_dvalid", bus.o_d_valid, 1); chk("t2_dstall", bus.o_d_stall, 0);
      chk("t2_istall", bus.o_i_stall, 1); bus.d_req = 0;
      step(); chk("t2_ireq", bus.mem_req, 1); chk("t2_iaddr", bus.mem_addr, 32'h4); chk("t2_iwe", bus.mem_we, 0);
      wait_valid(0, "t2"); bus.i_req = 0;
      // burst limit: D,D,D,D,I,D
      step(); bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h200; bus.i_req = 1; bus.i_addr = 32'h40;
      seq = '0; ng = 0; nd = 0; prev = 0;
      for (int n = 0; n < 200 && nd < 6; n++) begin
         step();
         if (bus.mem_req && !prev && ng < 6) begin seq = {seq[4:0], bus.mem_addr != 32'h40}; ng++; end
         prev = bus.mem_req;
         if (bus.o_d_valid) begin nd++; bus.d_addr = bus.d_addr + 4; if (nd == 6) bus.d_req = 0; end
         if (bus.o_i_valid) bus.i_req = 0;
      end
      chk("t3_order", seq, 6'b111101); chk("t3_loads", nd, 6);
      // mem_ready low for 5 cycles during I_REQ
      step(); force_low = 1; bus.i_req = 1; bus.i_addr = 32'h80;
      for (int k = 0; k < 5; k++) begin
         step(); chk("t4_req", bus.mem_req, 1); chk("t4_addr", bus.mem_addr, 32'h80);
      end
      force_low = 0;
      wait_valid(0, "t4"); chk("t4_rdata", bus.o_i_rdata, 32'h0080_FF7F); bus.i_req = 0;
      // reset during D_WAIT, stray rvalid afterwards
      step(); fixed_lat = 3; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300;
      step(); chk("t5_req", bus.mem_req, 1);
      step(); chk("t5_wait", bus.mem_req, 0); rst = 1'b0; bus.d_req = 0;
      #1 chk_zero("t5_async");
      step(); chk_zero("t5_held"); rst = 1'b1; fixed_lat = 1;
      step(); chk("t5_stray", bus.mem_rvalid, 1); chk("t5_dvalid_a", bus.o_d_valid, 0);
      step(); chk("t5_dvalid_b", bus.o_d_valid, 0); chk("t5_idle", bus.mem_req, 0);
      bus.i_req = 1; bus.i_addr = 32'h10;
      wait_valid(0, "t5"); chk("t5_rdata", bus.o_i_rdata, 32'h0051_0093); bus.i_req = 0;
      // spurious rvalid while idle
      step(); spur_now = 1;
      step(); spur_now = 0; chk("t6_spur", bus.mem_rdata, 32'hFFFF_FFFF);
      for (int k = 0; k < 2; k++) begin
         step(); chk("t6_ivalid", bus.o_i_valid, 0); chk("t6_dvalid", bus.o_d_valid, 0);
         chk("t6_irdata", bus.o_i_rdata, 32'h0051_0093); chk("t6_drdata", bus.o_d_rdata, 0);
      end
      // random traffic
      rand_ready = 1; fixed_lat = 0; spur_en = 1;
      for (int n = 0; n < 3000; n++) begin
         step();
         if (bus.o_i_valid) begin bus.i_req = 1'($urandom_range(0, 1)); bus.i_addr = $urandom; end
         else if (!bus.i_req) begin
            if ($urandom_range(0, 2) == 0) begin bus.i_req = 1; bus.i_addr = $urandom; end
         end else if ($urandom_range(0, 99) == 0) bus.i_req = 0;
         if (bus.o_d_valid) begin
            bus.d_req = 1'($urandom_range(0, 1)); bus.d_we = 1'($urandom_range(0, 1));
            bus.d_addr = $urandom; bus.d_wdata = $urandom;
         end else if (!bus.d_req) begin
            if ($urandom_range(0, 1) == 0) begin
               bus.d_req = 1; bus.d_we = 1'($urandom_range(0, 1));
               bus.d_addr = $urandom; bus.d_wdata = $urandom;
            end
         end else if ($urandom_range(0, 99) == 0) bus.d_req = 0;
      end
      bus.i_req = 0; bus.d_req = 0;
      repeat (30) step();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
